interval_timer_ctrl: RTL
========================

# interval_timer_ctrl

Programmable interval-timer controller that sequences an 8-bit up-counter datapath. A configuration handshake loads the terminal value, prescaler and mode. Start and stop controls then run the count in one-shot or periodic mode, raising a tick pulse and a sticky interrupt at terminal count. It sits between the register/host interface and the counter, and owns the counter's enable and clear.

## Interface
- WIDTH, 8: counter width.
- PW, 4: prescaler field width.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  controller accepts config; high in IDLE and DONE only.
- cfg_limit  in  WIDTH  terminal count value.
- cfg_prescale  in  PW  clock-enable divider; a step occurs every cfg_prescale+1 cycles.
- cfg_periodic  in  1  1 = reload and continue at terminal; 0 = one-shot.
- start  in  1  level-sampled run request.
- stop  in  1  abort to IDLE.
- irq_clr  in  1  clears irq.
- cnt_en  out  1  combinational step strobe (counter enable).
- count  out  WIDTH  current count.
- busy  out  1  high in RUN.
- tick  out  1  registered one-cycle terminal pulse.
- irq  out  1  sticky terminal flag.

## Operation
- States: IDLE, ARMED, RUN, DONE. Reset enters IDLE. Reset sets count=0, prescaler=0, tick=0, irq=0 and clears the stored limit, prescale and periodic fields.
- IDLE: cfg_valid & cfg_ready latches limit, prescale and periodic, clears count and prescaler, and moves to ARMED. start is ignored in IDLE.
- ARMED: start moves to RUN. cfg_valid is not accepted (cfg_ready=0).
- RUN: the prescaler counts 0..prescale. cnt_en=1 in a cycle where prescaler==prescale; in that cycle the prescaler returns to 0 and a step occurs.
  - Step with count≠limit: count increments by 1.
  - Step with count==limit (terminal):
    - tick=1 and irq=1 on the next cycle.
    - Periodic: count goes to 0 and the state stays RUN.
    - One-shot: count holds at limit and the state moves to DONE.
- DONE: start restarts with count=0, prescaler=0, same config, and moves to RUN. cfg_valid & cfg_ready latches a new config and moves to ARMED with count=0.
- stop in ARMED, RUN or DONE: moves to IDLE, count=0, prescaler=0. irq is not affected.
- Priority:
  - stop beats start, terminal and config.
  - A stop coinciding with a terminal step suppresses tick and irq set.
  - An irq set beats irq_clr in the same cycle.
- Arithmetic:
  - count never exceeds limit, so there is no natural wrap.
  - limit=0 makes every step terminal.
  - limit=2^WIDTH-1 gives 2^WIDTH steps per period.
- Period is (limit+1)*(prescale+1) cycles.

## Timing
- start sampled high at edge N: busy=1 from cycle N+1.
- The first cnt_en is at cycle N+1+prescale; count=1 is visible the cycle after that.
- tick is high exactly one cycle, the cycle after the terminal step. In periodic mode count reads 0 during that cycle.
- Periodic mode gives one tick every (limit+1)*(prescale+1) cycles with no gap between periods.
- One-shot: busy falls and cfg_ready rises in the same cycle tick rises.
- cnt_en is combinational from state and prescaler only, with no input-to-output path.
- rst_n assertion mid-run clears all outputs immediately, with no clock required. Operation resumes on the first edge after deassertion, in IDLE.

## Test plan
- Reset mid-RUN (limit=5, count=3): on rst_n low, count, busy, tick and irq are all 0 immediately; after release the state is IDLE and cfg_ready=1.
- One-shot, limit=3, prescale=0, start at cycle 0:
  - count reads 0,1,2,3 in cycles 1–4.
  - tick=1 only in cycle 5, count holds at 3, busy=0 and irq=1 from cycle 5.
- Periodic, limit=2, prescale=1: tick every 6 cycles for 4 periods; count sequence 0,0,1,1,2,2 repeating; cnt_en high on alternate cycles.
- stop asserted in the same cycle as a terminal step (limit=1, periodic): no tick and irq stays 0; next cycle is IDLE with count=0.
- irq_clr held high while a terminal occurs: irq reads 1 after the terminal; a later irq_clr with no terminal clears it to 0.
- Config handshake:
  - cfg_valid in ARMED and RUN sees cfg_ready=0 and leaves the config unchanged.
  - In DONE, a new config (limit=0, prescale=3) is accepted.
  - A subsequent one-shot run gives tick 4 cycles after busy rises.

Source files
------------

// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl: config handshake and start/stop sequencing for a prescaled up-counter with tick and sticky irq
module interval_timer_ctrl #(
  parameter int WIDTH = 8,
  parameter int PW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [PW-1:0]    cfg_prescale,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             stop,
  input  logic             irq_clr,
  output logic             cnt_en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tick,
  output logic             irq
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] limit, limit_n, count_n;
  logic [PW-1:0] pre, pre_n, prescale, prescale_n;
  logic periodic, periodic_n, tick_n, irq_n, cfg_acc, terminal;
  assign cfg_ready = (state == IDLE) || (state == DONE);
  assign busy = state == RUN;
  assign cnt_en = (state == RUN) && (pre == prescale);
  assign terminal = cnt_en && (count == limit);
  assign cfg_acc = cfg_valid && cfg_ready;
  always_comb begin
    state_n = state;
    count_n = count;
    pre_n = pre;
    limit_n = limit;
    prescale_n = prescale;
    periodic_n = periodic;
    tick_n = 1'b0;
    irq_n = irq && !irq_clr;
    if (stop && state != IDLE) begin
      state_n = IDLE;
      count_n = '0;
      pre_n = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (state == DONE && start) begin
            state_n = RUN;
            count_n = '0;
            pre_n = '0;
          end else if (cfg_acc) begin
            state_n = ARMED;
            limit_n = cfg_limit;
            prescale_n = cfg_prescale;
            periodic_n = cfg_periodic;
            count_n = '0;
            pre_n = '0;
          end
        end
        ARMED: state_n = start ? RUN : ARMED;
        RUN: begin
          pre_n = cnt_en ? '0 : pre + PW'(1);
          if (terminal) begin
            tick_n = 1'b1;
            irq_n = 1'b1;
            count_n = periodic ? '0 : count;
            state_n = periodic ? RUN : DONE;
          end else if (cnt_en) begin
            count_n = count + WIDTH'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      pre <= '0;
      limit <= '0;
      prescale <= '0;
      periodic <= 1'b0;
      tick <= 1'b0;
      irq <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      pre <= pre_n;
      limit <= limit_n;
      prescale <= prescale_n;
      periodic <= periodic_n;
      tick <= tick_n;
      irq <= irq_n;
    end
  end
endmodule
